// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and the fetch FSM state type for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned OpcodeW        = 6;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultPcStep  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Request/acknowledge bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset beats load, load beats increment; increment wraps modulo 2^ADDR_W.
module instr_fetch_unit_pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: IDLE -> REQ -> HOLD loop with an instruction register and deferred redirects
// so an in-flight memory request is never retracted.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int unsigned       PC_STEP  = DefaultPcStep
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [DATA_W-1:0]   instr,
  output logic [OpcodeW-1:0]  opCode,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                instr_valid
);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [OpcodeW-1:0] opcode_q, opcode_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_target, pc, redirect_aligned;

  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load),
    .target_i (pc_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    opcode_d  = opcode_q;
    pc_out_d  = pc_out_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_target = redirect_aligned;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        pc_load = redirect;
      end
      StReq: begin
        // Redirect before ack is parked; the request in flight completes and is dropped.
        if (redirect) begin
          if (imem.ack) begin
            pc_load = 1'b1;
            pend_d  = 1'b0;
          end else begin
            pend_d = 1'b1;
            tgt_d  = redirect_aligned;
          end
        end else if (imem.ack) begin
          if (pend_q) begin
            pc_load   = 1'b1;
            pc_target = tgt_q;
            pend_d    = 1'b0;
          end else begin
            instr_d  = imem.rdata;
            opcode_d = imem.rdata[DATA_W-1 -: OpcodeW];
            pc_out_d = pc;
            pc_inc   = 1'b1;
            valid_d  = 1'b1;
            state_d  = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = StReq;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opcode_q <= '0;
      pc_out_q <= '0;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      pc_out_q <= pc_out_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = pc;
  assign instr       = instr_q;
  assign opCode      = opcode_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule
